chicken_race_tracker: RTL and testbench

- Parametrised successor to the three-player win checker for the chicken-race board game.
- Tracks N player positions on a circular board and rotates the turn on a miss.
- Advances the current player by a variable step on a hit, and detects a win when the mover lands on another player's square.
- Sits between the tile-guess input logic and the display/score logic; a sequential FSM replaces the old combinational compare.

---
 rtl/chicken_race_tracker.sv | 191 +++++++++++++++++++
 tb/tb_chicken_race_tracker.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chicken_race_tracker.sv
// -----------------------------------------------------------------------------
// chicken_race_tracker
//
// Turn and position tracker for the chicken-race board game. N players sit on a
// circular board of BOARD_LEN squares. A miss passes the turn to the next
// player. A hit advances the current player by `step` squares and keeps the
// turn. If the mover lands on a square another player occupies, the mover wins.
// The game then freezes until new_game or rst.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   start      in   pulse; leaves IDLE and begins play
//   new_game   in   pulse; synchronous clear back to IDLE (highest priority)
//   move_req   in   pulse; one guess result is presented (ignored while busy)
//   hit        in   qualifies move_req: 1 = correct guess, 0 = miss
//   step       in   squares to advance on a hit
//   cur_player out  player whose turn it is
//   pos_bus    out  player i position in bits [i*POS_W +: POS_W]
//   busy       out  high during the one-cycle collision check
//   move_ack   out  one-cycle pulse when a move is fully resolved
//   win        out  high once a player has won
//   winner     out  winning player, valid while win = 1
// -----------------------------------------------------------------------------
module chicken_race_tracker #(
    parameter  int NUM_PLAYERS = 3,
    parameter  int BOARD_LEN   = 24,
    parameter  int STEP_W      = 3,
    localparam int POS_W       = $clog2(BOARD_LEN),
    localparam int PID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         new_game,
    input  logic                         move_req,
    input  logic                         hit,
    input  logic [STEP_W-1:0]            step,
    output logic [PID_W-1:0]             cur_player,
    output logic [NUM_PLAYERS*POS_W-1:0] pos_bus,
    output logic                         busy,
    output logic                         move_ack,
    output logic                         win,
    output logic [PID_W-1:0]             winner
);

    localparam int SPACING = BOARD_LEN / NUM_PLAYERS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_CHECK,
        ST_WIN
    } state_e;

    state_e           state_q, state_d;
    logic [PID_W-1:0] cur_q, cur_d;
    logic [PID_W-1:0] winner_q, winner_d;
    logic [POS_W-1:0] pos_q [NUM_PLAYERS];
    logic [POS_W-1:0] pos_d [NUM_PLAYERS];
    logic             ack_q, ack_d;
    logic             win_q, win_d;

    logic [POS_W:0]   pos_sum;
    logic [POS_W-1:0] pos_wrapped;
    logic [PID_W-1:0] next_player;
    logic             collide;

    // Starting square for each player: evenly spaced around the board.
    function automatic logic [POS_W-1:0] home_pos(input int idx);
        return POS_W'(idx * SPACING);
    endfunction

    // Advance arithmetic. step < BOARD_LEN, so one conditional subtract is a
    // complete modulo reduction.
    always_comb begin
        pos_sum     = {1'b0, pos_q[cur_q]} + (POS_W+1)'(step);
        pos_wrapped = pos_sum[POS_W-1:0];
        if (pos_sum >= (POS_W+1)'(BOARD_LEN)) begin
            pos_wrapped = POS_W'(pos_sum - (POS_W+1)'(BOARD_LEN));
        end
    end

    assign next_player = (cur_q == PID_W'(NUM_PLAYERS - 1)) ? '0 : cur_q + PID_W'(1);

    // The mover's square is compared against everyone else. Positions are
    // pairwise distinct outside WIN, so any match is a fresh landing.
    always_comb begin
        collide = 1'b0;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            if ((PID_W'(j) != cur_q) && (pos_q[j] == pos_q[cur_q])) begin
                collide = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        cur_d    = cur_q;
        pos_d    = pos_q;
        ack_d    = 1'b0;
        win_d    = win_q;
        winner_d = winner_q;

        if (new_game) begin
            state_d  = ST_IDLE;
            cur_d    = '0;
            win_d    = 1'b0;
            winner_d = '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                pos_d[i] = home_pos(i);
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (move_req) begin
                        if (hit) begin
                            pos_d[cur_q] = pos_wrapped;
                            state_d      = ST_CHECK;
                        end else begin
                            cur_d = next_player;
                            ack_d = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    ack_d = 1'b1;
                    if (collide) begin
                        win_d    = 1'b1;
                        winner_d = cur_q;
                        state_d  = ST_WIN;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_WIN: begin
                    // Frozen until new_game or rst.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            ack_q    <= 1'b0;
            win_q    <= 1'b0;
            winner_q <= '0;
            // NOTE: the position array is reset, unlike a data RAM, because
            // the distinct starting squares are part of the game state.
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                pos_q[i] <= home_pos(i);
            end
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            ack_q    <= ack_d;
            win_q    <= win_d;
            winner_q <= winner_d;
            pos_q    <= pos_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PLAYERS; g++) begin : g_pos_bus
            assign pos_bus[g*POS_W +: POS_W] = pos_q[g];
        end
    endgenerate

    assign cur_player = cur_q;
    assign busy       = (state_q == ST_CHECK);
    assign move_ack   = ack_q;
    assign win        = win_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_chicken_race_tracker.sv
// -----------------------------------------------------------------------------
// Self-checking bench for chicken_race_tracker.
// The main instance uses the default parameters (3 players, 24 squares). A
// second instance uses 4 players and 32 squares and gets a short directed run.
// -----------------------------------------------------------------------------
module tb_chicken_race_tracker;

    localparam int NP  = 3;
    localparam int BL  = 24;
    localparam int SW  = 3;
    localparam int PW  = 5;
    localparam int IW  = 2;
    localparam int NP4 = 4;
    localparam int BL4 = 32;
    localparam int PW4 = 5;
    localparam int IW4 = 2;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_CHECK = 2;
    localparam int M_WIN   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Main instance signals.
    logic          start = 1'b0, new_game = 1'b0, move_req = 1'b0, hit = 1'b0;
    logic [SW-1:0] step = '0;
    logic [IW-1:0] cur_player, winner;
    logic [NP*PW-1:0] pos_bus;
    logic          busy, move_ack, win;

    // Second instance signals.
    logic          start4 = 1'b0, new_game4 = 1'b0, move_req4 = 1'b0, hit4 = 1'b0;
    logic [SW-1:0] step4 = '0;
    logic [IW4-1:0] cur_player4, winner4;
    logic [NP4*PW4-1:0] pos_bus4;
    logic          busy4, move_ack4, win4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    chicken_race_tracker #(.NUM_PLAYERS(NP), .BOARD_LEN(BL), .STEP_W(SW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .new_game(new_game),
        .move_req(move_req), .hit(hit), .step(step),
        .cur_player(cur_player), .pos_bus(pos_bus), .busy(busy),
        .move_ack(move_ack), .win(win), .winner(winner)
    );

    chicken_race_tracker #(.NUM_PLAYERS(NP4), .BOARD_LEN(BL4), .STEP_W(SW)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .new_game(new_game4),
        .move_req(move_req4), .hit(hit4), .step(step4),
        .cur_player(cur_player4), .pos_bus(pos_bus4), .busy(busy4),
        .move_ack(move_ack4), .win(win4), .winner(winner4)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Game-level view: squares as integers, modulo arithmetic, and a count of
    // how many players occupy the mover's square.
    int m_pos [NP];
    int m_cur, m_mode, m_winner;
    bit m_ack, m_win;

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_pos[i] = i * (BL / NP);
        m_cur    = 0;
        m_mode   = M_IDLE;
        m_ack    = 1'b0;
        m_win    = 1'b0;
        m_winner = 0;
    endtask

    function automatic int occupants(input int sq);
        int n = 0;
        for (int i = 0; i < NP; i++) if (m_pos[i] == sq) n++;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || new_game) begin
            model_reset();
        end else begin
            m_ack = 1'b0;
            case (m_mode)
                M_IDLE:  if (start) m_mode = M_PLAY;
                M_PLAY: begin
                    if (move_req) begin
                        if (hit) begin
                            m_pos[m_cur] = (m_pos[m_cur] + int'(step)) % BL;
                            m_mode = M_CHECK;
                        end else begin
                            m_cur = (m_cur + 1) % NP;
                            m_ack = 1'b1;
                        end
                    end
                end
                M_CHECK: begin
                    m_ack = 1'b1;
                    if (occupants(m_pos[m_cur]) > 1) begin
                        m_win    = 1'b1;
                        m_winner = m_cur;
                        m_mode   = M_WIN;
                    end else begin
                        m_mode = M_PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------- compare process
    always @(negedge clk) begin
        if (!rst) begin
            check("cur_player", cur_player, m_cur);
            for (int i = 0; i < NP; i++) begin
                check($sformatf("pos%0d", i), pos_bus[i*PW +: PW], m_pos[i]);
            end
            check("busy", busy, (m_mode == M_CHECK));
            check("move_ack", move_ack, m_ack);
            check("win", win, m_win);
            if (m_win) check("winner", winner, m_winner);
        end
    end

    // ------------------------------------------------------------- stimulus
    function automatic int p(input int i);
        return int'(pos_bus[i*PW +: PW]);
    endfunction

    function automatic int p4(input int i);
        return int'(pos_bus4[i*PW4 +: PW4]);
    endfunction

    // Present one cycle of inputs (called just after a falling edge), then
    // clear them at the next falling edge.
    task automatic drive(input logic s, input logic ng, input logic mr,
                         input logic h, input int st);
        start = s; new_game = ng; move_req = mr; hit = h; step = SW'(st);
        @(negedge clk);
        start = 1'b0; new_game = 1'b0; move_req = 1'b0; hit = 1'b0; step = '0;
    endtask

    task automatic drive4(input logic s, input logic mr, input logic h, input int st);
        start4 = s; move_req4 = mr; hit4 = h; step4 = SW'(st);
        @(negedge clk);
        start4 = 1'b0; move_req4 = 1'b0; hit4 = 1'b0; step4 = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_pos_bus", pos_bus, {5'd16, 5'd8, 5'd0});
        check("reset_cur", cur_player, 0);
        check("reset_busy", busy, 0);
        check("reset_ack", move_ack, 0);
        check("reset_win", win, 0);
        #1 rst = 1'b0;

        drive(1, 0, 0, 0, 0);                       // start
        check("start_cur", cur_player, 0);
        drive(0, 0, 1, 0, 0);
        check("miss1_cur", cur_player, 1);
        check("miss1_ack", move_ack, 1);
        drive(0, 0, 0, 0, 0);
        check("idle_ack", move_ack, 0);
        drive(0, 0, 1, 0, 0);
        check("miss2_cur", cur_player, 2);
        drive(0, 0, 1, 0, 0);
        check("miss3_wrap", cur_player, 0);
        check("miss3_ack", move_ack, 1);

        drive(0, 0, 1, 1, 3);                       // player 0 hit +3
        check("hit3_pos0", p(0), 3);
        check("hit3_busy", busy, 1);
        check("hit3_ack_early", move_ack, 0);
        drive(0, 0, 0, 0, 0);
        check("hit3_busy_done", busy, 0);
        check("hit3_ack", move_ack, 1);
        check("hit3_win", win, 0);
        check("hit3_keep_turn", cur_player, 0);

        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 1, 6);                       // player 2: 16 -> 22
        check("p2_22", p(2), 22);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 4);                       // 22 + 4 wraps to 2
        check("p2_wrap", p(2), 2);
        drive(0, 0, 0, 0, 0);
        check("wrap_win", win, 0);
        check("wrap_ack", move_ack, 1);
        check("wrap_cur", cur_player, 2);

        drive(0, 0, 1, 0, 0);                       // turn back to player 0
        drive(0, 0, 1, 1, 5);                       // 3 + 5 = 8 lands on player 1
        check("land_pos0", p(0), 8);
        check("land_win_early", win, 0);
        drive(0, 0, 0, 0, 0);
        check("land_win", win, 1);
        check("land_winner", winner, 0);
        check("land_ack", move_ack, 1);
        drive(1, 0, 1, 1, 2);                       // ignored in WIN
        check("win_hold_pos0", p(0), 8);
        check("win_hold_win", win, 1);
        check("win_hold_ack", move_ack, 0);
        check("win_hold_busy", busy, 0);
        drive(0, 0, 1, 0, 0);
        check("win_hold_cur", cur_player, 0);

        drive(0, 1, 0, 0, 0);                       // new_game
        check("ng_pos_bus", pos_bus, {5'd16, 5'd8, 5'd0});
        check("ng_win", win, 0);
        drive(0, 0, 1, 1, 3);                       // ignored in IDLE
        check("idle_hit_pos0", p(0), 0);
        check("idle_hit_busy", busy, 0);
        drive(0, 0, 1, 0, 0);
        check("idle_miss_cur", cur_player, 0);
        check("idle_miss_ack", move_ack, 0);

        drive(1, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 3);                       // new_game beats move_req
        check("ng_vs_move_pos0", p(0), 0);
        check("ng_vs_move_busy", busy, 0);

        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 2);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_pos_bus", pos_bus, {5'd16, 5'd8, 5'd0});
        check("async_rst_ack", move_ack, 0);
        check("async_rst_win", win, 0);
        @(negedge clk);
        check("async_rst_no_ack", move_ack, 0);
        #1 rst = 1'b0;

        // Randomised play, checked every cycle by the compare process.
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            logic s, ng, mr, h;
            int   st;
            s  = ($urandom_range(0, 7) == 0);
            ng = m_win ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
            mr = $urandom_range(0, 1) != 0;
            h  = $urandom_range(0, 2) != 0;
            st = $urandom_range(0, 7);
            drive(s, ng, mr, h, st);
        end

        // Four-player, 32-square instance.
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        check("np4_reset_pos_bus", pos_bus4, {5'd24, 5'd16, 5'd8, 5'd0});
        check("np4_reset_cur", cur_player4, 0);
        drive4(1, 0, 0, 0);
        drive4(0, 1, 1, 7);
        check("np4_hit_pos0", p4(0), 7);
        check("np4_hit_busy", busy4, 1);
        drive4(0, 0, 0, 0);
        check("np4_hit_ack", move_ack4, 1);
        drive4(0, 1, 0, 0);
        check("np4_miss_cur", cur_player4, 1);
        drive4(0, 1, 0, 0);
        drive4(0, 1, 0, 0);
        check("np4_cur3", cur_player4, 3);
        drive4(0, 1, 1, 7);                         // 24 + 7 = 31
        drive4(0, 0, 0, 0);
        check("np4_pos3_31", p4(3), 31);
        drive4(0, 1, 1, 1);                         // 31 + 1 wraps to 0
        drive4(0, 0, 0, 0);
        check("np4_pos3_wrap", p4(3), 0);
        check("np4_wrap_win", win4, 0);
        check("np4_wrap_ack", move_ack4, 1);
        drive4(0, 1, 0, 0);
        check("np4_cur_wrap", cur_player4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
